// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: scan states, active-low glyph constants and
// the decimal glyph lookup used by every display block on the board.
package seg7_pkg;

  typedef enum logic [1:0] {
    ONES = 2'd0,
    TENS = 2'd1,
    SIGN = 2'd2
  } scan_state_e;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [2:0] AN_OFF    = 3'b111;

  // Active-low {g,f,e,d,c,b,a}; anything above 9 renders blank.
  function automatic logic [6:0] digit_glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'd0:    g = 7'b1000000;
      4'd1:    g = 7'b1111001;
      4'd2:    g = 7'b0100100;
      4'd3:    g = 7'b0110000;
      4'd4:    g = 7'b0011001;
      4'd5:    g = 7'b0010010;
      4'd6:    g = 7'b0000010;
      4'd7:    g = 7'b1111000;
      4'd8:    g = 7'b0000000;
      4'd9:    g = 7'b0010000;
      default: g = SEG_BLANK;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/sub_result_display_if.sv
// Capture/display bundle between the subtractor side and the display stage.
interface sub_result_display_if;
  logic [4:0] d_in;
  logic       d_valid;
  logic [6:0] seg;
  logic [2:0] an;
  logic       neg;
  logic [4:0] result_q;

  modport master (output d_in, d_valid, input seg, an, neg, result_q);
  modport slave  (input d_in, d_valid, output seg, an, neg, result_q);
endinterface

// File: rtl/seg7_decoder.sv
// Combinational 4-bit digit to active-low 7-segment glyph with blanking.
module seg7_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] i_digit,
  input  logic       i_blank,
  output logic [6:0] o_seg
);

  assign o_seg = i_blank ? SEG_BLANK : digit_glyph(i_digit);

endmodule

// File: rtl/sub_result_display.sv
// Captures the 5-bit subtractor result, converts it to sign-magnitude decimal
// and scans it across three multiplexed 7-segment digits (sign, tens, ones).
module sub_result_display
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input logic clk,
  input logic rst,
  sub_result_display_if.slave bus
);

  localparam int                CNT_W    = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [6:0]        SEG_INV  = SEG_ACTIVE_LOW ? 7'h00 : 7'h7F;
  localparam logic [2:0]        AN_INV   = SEG_ACTIVE_LOW ? 3'b000 : 3'b111;

  logic [4:0]       r_result_p0;
  logic             r_neg_p1;
  logic [4:0]       r_mag_p1;
  logic [4:0]       w_mag;
  logic             w_tens;
  logic [3:0]       w_ones;
  scan_state_e      r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [3:0]       w_digit;
  logic             w_blank;
  logic [6:0]       w_dec_seg;
  logic [6:0]       w_seg_al;
  logic [2:0]       w_an_al;
  logic [6:0]       r_seg_p2;
  logic [2:0]       r_an_p2;

  // Stage p0: capture
  always_ff @(posedge clk) begin
    if (rst)               r_result_p0 <= '0;
    else if (bus.d_valid)  r_result_p0 <= bus.d_in;
  end

  // Stage p1: sign-magnitude; a borrow with a zero nibble deliberately yields 16
  assign w_mag = r_result_p0[4] ? (5'd16 - {1'b0, r_result_p0[3:0]})
                                : {1'b0, r_result_p0[3:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_neg_p1 <= 1'b0;
      r_mag_p1 <= '0;
    end else begin
      r_neg_p1 <= r_result_p0[4];
      r_mag_p1 <= w_mag;
    end
  end

  assign w_tens = (r_mag_p1 >= 5'd10);
  assign w_ones = w_tens ? 4'(r_mag_p1 - 5'd10) : r_mag_p1[3:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ONES;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 1'b1;
    if (r_cnt == CNT_LAST) begin
      w_cnt_nxt = '0;
      case (r_state)
        ONES:    w_state_nxt = TENS;
        TENS:    w_state_nxt = SIGN;
        default: w_state_nxt = ONES;
      endcase
    end
  end

  seg7_decoder u_dec (
    .i_digit (w_digit),
    .i_blank (w_blank),
    .o_seg   (w_dec_seg)
  );

  // Digit content and enable for the slot currently being scanned
  always_comb begin
    w_digit  = w_ones;
    w_blank  = 1'b0;
    w_an_al  = 3'b110;
    w_seg_al = w_dec_seg;
    case (r_state)
      ONES: ;
      TENS: begin
        w_digit = 4'd1;
        w_blank = ~w_tens;
        w_an_al = 3'b101;
      end
      SIGN: begin
        w_an_al  = 3'b011;
        w_seg_al = r_neg_p1 ? SEG_MINUS : SEG_BLANK;
      end
      default: begin
        w_an_al  = AN_OFF;
        w_seg_al = SEG_BLANK;
      end
    endcase
  end

  // Stage p2: seg and an leave together from one register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg_p2 <= SEG_BLANK ^ SEG_INV;
      r_an_p2  <= AN_OFF ^ AN_INV;
    end else begin
      r_seg_p2 <= w_seg_al ^ SEG_INV;
      r_an_p2  <= w_an_al ^ AN_INV;
    end
  end

  assign bus.seg      = r_seg_p2;
  assign bus.an       = r_an_p2;
  assign bus.neg      = r_neg_p1;
  assign bus.result_q = r_result_p0;

endmodule

// File: tb/tb_sub_result_display.sv
// Directed bench for sub_result_display: one active-low and one active-high
// instance, SCAN_DIV=4, checked with immediate assertions.
module tb_sub_result_display;

  localparam logic [6:0] G_BLANK = 7'b1111111;
  localparam logic [6:0] G_MINUS = 7'b0111111;
  localparam logic [6:0] G_0     = 7'b1000000;
  localparam logic [6:0] G_1     = 7'b1111001;
  localparam logic [6:0] G_2     = 7'b0100100;
  localparam logic [6:0] G_3     = 7'b0110000;
  localparam logic [6:0] G_5     = 7'b0010010;
  localparam logic [6:0] G_6     = 7'b0000010;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  sub_result_display_if bus_al ();
  sub_result_display_if bus_ah ();

  sub_result_display #(.SCAN_DIV(4), .SEG_ACTIVE_LOW(1'b1)) dut_al (
    .clk (clk),
    .rst (rst),
    .bus (bus_al)
  );

  sub_result_display #(.SCAN_DIV(4), .SEG_ACTIVE_LOW(1'b0)) dut_ah (
    .clk (clk),
    .rst (rst),
    .bus (bus_ah)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] d, input logic v);
    bus_al.d_in = d;  bus_al.d_valid = v;
    bus_ah.d_in = d;  bus_ah.d_valid = v;
  endtask

  task automatic chk_disp(input string tag, input logic [2:0] e_an, input logic [6:0] e_seg);
    chk({tag, "_an"},    {5'd0, bus_al.an},  {5'd0, e_an});
    chk({tag, "_seg"},   {1'b0, bus_al.seg}, {1'b0, e_seg});
    chk({tag, "_an_h"},  {5'd0, bus_ah.an},  {5'd0, ~e_an});
    chk({tag, "_seg_h"}, {1'b0, bus_ah.seg}, {1'b0, ~e_seg});
  endtask

  task automatic chk_reset(input string tag);
    chk_disp(tag, 3'b111, G_BLANK);
    chk({tag, "_neg"}, {7'd0, bus_al.neg},      8'd0);
    chk({tag, "_rq"},  {3'd0, bus_al.result_q}, 8'd0);
  endtask

  // Twelve edges starting with the first edge of an ONES slot
  task automatic frame(input string tag, input logic [6:0] e_ones,
                       input logic [6:0] e_tens, input logic [6:0] e_sign);
    for (int i = 0; i < 12; i++) begin
      tick();
      case (i / 4)
        0:       chk_disp({tag, "_ones"}, 3'b110, e_ones);
        1:       chk_disp({tag, "_tens"}, 3'b101, e_tens);
        default: chk_disp({tag, "_sign"}, 3'b011, e_sign);
      endcase
    end
  endtask

  // One-cycle capture, then d_in changes with d_valid low; 12 edges total
  task automatic capture(input string tag, input logic [4:0] v, input logic e_neg);
    drive(v, 1'b1);
    tick();
    chk({tag, "_rq"}, {3'd0, bus_al.result_q}, {3'd0, v});
    drive(~v, 1'b0);
    tick();
    chk({tag, "_neg"},  {7'd0, bus_al.neg},      {7'd0, e_neg});
    chk({tag, "_hold"}, {3'd0, bus_al.result_q}, {3'd0, v});
    for (int i = 0; i < 10; i++) tick();
  endtask

  initial begin
    drive(5'd0, 1'b0);
    // Reset with random inputs
    for (int i = 0; i < 3; i++) begin
      drive(5'($urandom), 1'($urandom));
      tick();
    end
    chk_reset("reset");
    rst = 1'b0;
    drive(5'd0, 1'b0);

    // Idle scan: 0 on ONES, blank elsewhere, twice round
    frame("idle1", G_0, G_BLANK, G_BLANK);
    frame("idle2", G_0, G_BLANK, G_BLANK);

    // 5-2 = 3
    capture("cap3", 5'b00011, 1'b0);
    frame("pos3", G_3, G_BLANK, G_BLANK);

    // 2-5 = -3
    capture("capm3", 5'b11101, 1'b1);
    frame("neg3", G_3, G_BLANK, G_MINUS);

    // d_valid held high re-captures each edge; final value 12
    drive(5'b00111, 1'b1);
    tick();
    chk("held1_rq", {3'd0, bus_al.result_q}, 8'd7);
    drive(5'b01100, 1'b1);
    tick();
    chk("held2_rq", {3'd0, bus_al.result_q}, 8'd12);
    drive(5'b00000, 1'b0);
    tick();
    chk("held_neg", {7'd0, bus_al.neg}, 8'd0);
    for (int i = 0; i < 9; i++) tick();
    frame("pos12", G_2, G_1, G_BLANK);

    // Borrow with zero nibble shows -16
    capture("capm16", 5'b10000, 1'b1);
    frame("neg16", G_6, G_1, G_MINUS);

    // Capture on the edge where ONES hands over to TENS
    for (int i = 0; i < 3; i++) tick();
    drive(5'b00101, 1'b1);
    tick();
    chk_disp("edge_n4", 3'b110, G_6);
    chk("edge_rq", {3'd0, bus_al.result_q}, 8'd5);
    drive(5'd0, 1'b0);
    tick();
    chk_disp("edge_n5", 3'b101, G_1);
    chk("edge_neg", {7'd0, bus_al.neg}, 8'd0);
    tick();
    chk_disp("edge_n6", 3'b101, G_BLANK);
    tick();
    tick();
    chk_disp("edge_n8", 3'b101, G_BLANK);
    tick();
    chk_disp("edge_n9", 3'b011, G_BLANK);
    for (int i = 0; i < 3; i++) tick();
    tick();
    chk_disp("edge_n13", 3'b110, G_5);
    tick();

    // Reset in the middle of a digit
    rst = 1'b1;
    tick();
    chk_reset("midrst");
    rst = 1'b0;
    frame("post_rst", G_0, G_BLANK, G_BLANK);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sub_result_display.md
Name: sub_result_display

Overview:
Downstream stage of the 4-bit ripple-borrow subtractor. Captures its 5-bit result (bit 4 = borrow) and converts it to sign-magnitude decimal. Time-multiplexes three 7-segment digits (sign, tens, ones) on the lab board. Also exposes the captured raw result and a negative flag for LEDs.

Parameters:
SCAN_DIV, 50000, clock cycles each digit stays enabled (must be >= 2; use 4 in simulation)
SEG_ACTIVE_LOW, 1, 1 = segment and anode outputs are active-low; 0 = active-high

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
d_in  input  5  subtractor result; d_in[4] = borrow, d_in[3:0] = A-B mod 16
d_valid  input  1  capture strobe; d_in is sampled on any clk edge where this is high
seg  output  7  segment drive, bit order {g,f,e,d,c,b,a}
an  output  3  digit enables, one-hot when active; an[0] = ones, an[1] = tens, an[2] = sign
neg  output  1  registered sign of the captured result
result_q  output  5  registered copy of the last captured d_in

Behaviour:
- Single clock domain. Reset is synchronous, active-high, and takes priority over every other input.
- Reset values:
  - result_q = 0, neg = 0, internal magnitude = 0.
  - Scan state = ONES, scan counter = 0.
  - seg = all off (7'b1111111 when active-low), an = all off (3'b111 when active-low).
- Capture:
  - Edge with d_valid=1: result_q <= d_in.
  - d_valid held high re-captures on every cycle.
  - d_valid=0: result_q holds its value.
- Conversion (registered, 1 cycle after capture):
  - neg <= result_q[4].
  - mag (5 bits) <= neg ? (16 - result_q[3:0]) : result_q[3:0].
  - Borrow with low nibble 0 (5'b10000) yields mag = 16 and displays "-16". Defined behaviour, never produced by a legal subtractor.
  - tens = (mag >= 10), ones = mag - 10*tens. Divider-free compare/subtract only.
- Total latency: d_valid edge -> seg content reflects the new value on the 2nd following edge, i.e. once the scan reaches that digit.
- Scan FSM: states ONES -> TENS -> SIGN -> ONES.
  - Counter runs 0..SCAN_DIV-1.
  - At SCAN_DIV-1 the counter returns to 0 and the state advances on the same edge.
  - Each digit is enabled for exactly SCAN_DIV cycles.
- Digit content:
  - ONES: decimal glyph of ones, always shown, so 0 displays "0".
  - TENS: glyph "1" if tens, else blank (leading-zero blanking).
  - SIGN: minus (segment g only) if neg, else blank.
- seg and an are registered together from the state and digit content, so they are never skewed.
  - First edge after reset release: ONES enabled showing "0".
  - an is exactly one-hot; never two digits on at once.
- Polarity: when SEG_ACTIVE_LOW=0, seg and an are the bitwise inverse of the active-low encodings.
- Simultaneous events:
  - A capture during a digit change does not disturb scan timing.
  - A new value appears on the next digit displayed after conversion.
- Reset mid-scan or mid-conversion: on the next edge all outputs return to reset values and the scan restarts at ONES with counter 0.

Decomposition:
- Shared package (seg7_pkg):
  - Scan state enum {ONES, TENS, SIGN}.
  - Active-low glyph constants: SEG_BLANK=7'b1111111, SEG_MINUS=7'b0111111.
  - Function mapping 0-9 to active-low gfedcba.
- One natural sub-module: seg7_decoder, a combinational 4-bit digit to 7-bit glyph decoder with a blank input. It is reused by future display blocks.

Test Plan:
1. rst=1 for 3 cycles with random d_in/d_valid -> seg=7'b1111111, an=3'b111, neg=0, result_q=0. First edge after release: an=3'b110, seg=7'b1000000 ("0").
2. SCAN_DIV=4, no capture -> an sequence 110,101,011,110 with each value held exactly 4 cycles. TENS and SIGN slots show 7'b1111111.
3. d_in=5'b00011 (5-2), one-cycle d_valid -> result_q=3 next edge, neg=0 after 2 edges. ONES slot shows 7'b0110000; TENS and SIGN are blank.
4. d_in=5'b11101 (2-5) -> neg=1, mag=3. SIGN slot shows 7'b0111111, ONES slot 7'b0110000, TENS blank.
5. d_in=5'b01100 (12) -> TENS 7'b1111001, ONES 7'b0100100. Then d_in=5'b10000 -> display "-16": SIGN minus, TENS 7'b1111001, ONES 7'b0000010.
6. d_valid on the same edge as a digit change, then rst pulsed mid-digit -> scan cadence unchanged until reset. One edge after rst: all outputs at reset values, counter restarts at 0.
